syncram_dp: RTL

- Parametrised successor to the 8-bit single-port synchronous RAM: simple dual-port memory with one write port, one read port and per-byte write enables.
- Adds a selectable read-during-write policy, an optional output pipeline register, and a hardware clear sequencer that zero-fills the array after reset or on request.
- Used as the general scratch/buffer memory for datapath blocks in the same design.

---
 rtl/syncram_dp.sv | 137 +++++++++++++
 1 files changed

// File: rtl/syncram_dp.sv
// syncram_dp: simple dual-port synchronous RAM with per-byte write enables,
// selectable read-during-write policy, optional output register and a
// hardware zero-fill sequencer that runs after reset or on clr_req.
module syncram_dp #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int RDW_MODE = 0,
    parameter int OUT_REG  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              busy,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int LANES = DATA_W / 8;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_fire;
    logic              rd_fire;
    logic [DATA_W-1:0] wr_merged;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] s1_data;
    logic              s1_valid;

    // The clear sweep owns the array, so user accesses are dropped while busy.
    assign wr_fire = wr_en && !busy;
    assign rd_fire = rd_en && !busy;

    // Build the post-write word: enabled byte lanes from wr_data, the rest old.
    always_comb begin
        wr_merged = mem[wr_addr];
        for (int i = 0; i < LANES; i++) begin
            if (wr_be[i]) begin
                wr_merged[8*i +: 8] = wr_data[8*i +: 8];
            end
        end
    end

    // Select the word returned by a read, applying the same-address collision policy.
    always_comb begin
        rd_word = mem[rd_addr];
        if ((RDW_MODE != 0) && wr_fire && (wr_addr == rd_addr)) begin
            rd_word = wr_merged;
        end
    end

    // Clear sequencer: sweeps every address once, then waits for clr_req.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLEAR;
            clr_ptr <= '0;
            busy    <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    clr_ptr <= clr_ptr + ADDR_W'(1);
                    if (clr_ptr == LAST_ADDR) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                IDLE: begin
                    if (clr_req) begin
                        state   <= CLEAR;
                        clr_ptr <= '0;
                        busy    <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Array write port: zero-fill during the sweep, otherwise the byte-merged user write.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[clr_ptr] <= '0;
        end else if (wr_fire) begin
            mem[wr_addr] <= wr_merged;
        end
    end

    // First read stage: registered array output, data held between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_fire;
            if (rd_fire) begin
                s1_data <= rd_word;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            // Optional extra output stage, adding one cycle of read latency.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_valid <= 1'b0;
                    rd_data  <= '0;
                end else begin
                    rd_valid <= s1_valid;
                    if (s1_valid) begin
                        rd_data <= s1_data;
                    end
                end
            end
        end else begin : g_out_direct
            assign rd_valid = s1_valid;
            assign rd_data  = s1_data;
        end
    endgenerate

endmodule
